// File: rtl/lif_neuron_bank.sv
// lif_neuron_bank: N independent leaky integrate-and-fire neurons that share one
// timestep strobe. Each channel integrates its own unsigned input current, leaks
// (a constant or a fraction of the voltage), fires when the updated voltage reaches
// VTH, resets (to zero or subtractively), then ignores input for REFRAC steps.
// A saturating bank-wide counter totals the spikes emitted.
module lif_neuron_bank #(
  parameter int N          = 4,
  parameter int IW         = 8,
  parameter int VW         = 12,
  parameter int VTH        = 200,
  parameter int LEAK_MODE  = 0,
  parameter int LEAK       = 5,
  parameter int LEAK_SHIFT = 3,
  parameter int RESET_MODE = 0,
  parameter int REFRAC     = 2,
  parameter int CW         = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step,
  input  logic [N*IW-1:0]  current,
  input  logic             cnt_clr,
  output logic [N-1:0]     spike,
  output logic [N*VW-1:0]  voltage,
  output logic [N-1:0]     refractory,
  output logic [CW-1:0]    spike_count
);

  // Refractory counter width, popcount width and the widened sum for saturation.
  localparam int RW = (REFRAC < 2) ? 1 : $clog2(REFRAC + 1);
  localparam int PW = $clog2(N + 1);
  localparam int SW = CW + PW + 1;

  localparam logic [VW-1:0] VTH_V   = VW'(VTH);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INTEG  = 2'd1,
    S_REFRAC = 2'd2
  } state_e;

  // A threshold the voltage register can never hold would make the neuron mute.
  if (VTH >= (1 << VW)) begin : g_vth_check
    $error("lif_neuron_bank: VTH must be below 2**VW");
  end

  // Per-channel fire decision for the current edge; feeds the spike counter.
  logic [N-1:0] fire_now;

  for (genvar k = 0; k < N; k++) begin : g_ch
    state_e          state_q;
    logic [VW-1:0]   v_q;
    logic [RW-1:0]   cnt_q;
    logic            spike_q;
    logic            refrac_q;

    logic [IW-1:0]   i_k;
    logic [VW:0]     s_w;
    logic [VW:0]     l_w;
    logic [VW:0]     d_w;
    logic [VW-1:0]   v_new;
    logic [VW-1:0]   v_fired;
    logic            active;

    assign i_k = current[k*IW +: IW];

    // Integrate-and-leak arithmetic: clamp at zero, saturate at the top of VW.
    always_comb begin
      // NOTE: every signal is assigned on every pass through this block, so
      // no path leaves a value remembered and no latch is inferred.
      s_w     = {1'b0, v_q} + (VW+1)'(i_k);
      l_w     = (LEAK_MODE == 0) ? (VW+1)'(LEAK) : {1'b0, v_q >> LEAK_SHIFT};
      d_w     = s_w - l_w;
      v_new   = (s_w < l_w) ? '0 : (d_w[VW] ? '1 : d_w[VW-1:0]);
      v_fired = (RESET_MODE != 0) ? (v_new - VTH_V) : '0;
      // An idle channel wakes only on non-zero input; refractory ignores input.
      active  = step && ((state_q == S_INTEG) ||
                         ((state_q == S_IDLE) && (i_k != '0)));
    end

    assign fire_now[k] = active && (v_new >= VTH_V);

    // Channel FSM: IDLE/INTEG integrate, firing is a transition into REFRAC.
    always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: every register here, including the refractory counter, takes the
      // asynchronous reset; there is no memory array that could hold stale state.
      if (!reset_n) begin
        state_q  <= S_IDLE;
        v_q      <= '0;
        cnt_q    <= '0;
        spike_q  <= 1'b0;
        refrac_q <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments so every register sees pre-edge values
        // regardless of statement order.
        spike_q <= fire_now[k];
        if (step) begin
          unique case (state_q)
            S_REFRAC: begin
              if (cnt_q == RW'(1)) begin
                state_q  <= S_INTEG;
                refrac_q <= 1'b0;
                cnt_q    <= '0;
              end else begin
                cnt_q <= cnt_q - RW'(1);
              end
            end
            default: begin
              if (active) begin
                if (fire_now[k]) begin
                  v_q <= v_fired;
                  if (REFRAC > 0) begin
                    state_q  <= S_REFRAC;
                    refrac_q <= 1'b1;
                    cnt_q    <= RW'(REFRAC);
                  end else begin
                    state_q <= S_INTEG;
                  end
                end else begin
                  v_q     <= v_new;
                  state_q <= ((v_new == '0) && (i_k == '0)) ? S_IDLE : S_INTEG;
                end
              end
            end
          endcase
        end
      end
    end

    assign spike[k]               = spike_q;
    assign voltage[k*VW +: VW]    = v_q;
    assign refractory[k]          = refrac_q;
  end

  logic [PW-1:0] pop;
  logic [SW-1:0] sum_w;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Spikes emitted this edge, added to (or replacing) the running total, saturating.
  always_comb begin
    pop = '0;
    for (int k = 0; k < N; k++) begin
      pop = pop + PW'(fire_now[k]);
    end
    sum_w   = (cnt_clr ? '0 : SW'(count_q)) + SW'(pop);
    count_d = (sum_w > SW'(CNT_MAX)) ? CNT_MAX : sum_w[CW-1:0];
  end

  // Bank-wide spike counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign spike_count = count_q;

endmodule
